// File: rtl/async_fifo_if.sv
// -----------------------------------------------------------------------------
// async_fifo_if -- handshake/data bundle for async_fifo.
//
// Carries both domains' request, data and flag signals. Clocks and resets are
// kept outside the interface so each domain's timing is explicit at the ports.
//
//   W_INC    write request              (write domain, master -> slave)
//   WR_DATA  write data                 (write domain, master -> slave)
//   FULL     full flag                  (write domain, slave  -> master)
//   R_INC    read request               (read domain,  master -> slave)
//   EMPTY    empty flag                 (read domain,  slave  -> master)
//   RD_DATA  registered read data       (read domain,  slave  -> master)
//
// master : the producer/consumer side (testbench or surrounding logic)
// slave  : the FIFO itself
// -----------------------------------------------------------------------------
interface async_fifo_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  W_INC;
  logic [DATA_WIDTH-1:0] WR_DATA;
  logic                  FULL;
  logic                  R_INC;
  logic                  EMPTY;
  logic [DATA_WIDTH-1:0] RD_DATA;

  modport master (
    output W_INC,
    output WR_DATA,
    output R_INC,
    input  FULL,
    input  EMPTY,
    input  RD_DATA
  );

  modport slave (
    input  W_INC,
    input  WR_DATA,
    input  R_INC,
    output FULL,
    output EMPTY,
    output RD_DATA
  );

endinterface : async_fifo_if

// File: rtl/async_fifo.sv
// -----------------------------------------------------------------------------
// async_fifo -- dual-clock FIFO with Gray-coded pointer synchronization.
//
// Parameters
//   DATA_WIDTH  word width in bits
//   DATA_DEP    depth in words (power of two, >= 4)
//
// Ports
//   W_CLK    write-domain clock
//   W_RST    write-domain reset, asynchronous, active-low
//   R_CLK    read-domain clock, asynchronous to W_CLK
//   R_RST    read-domain reset, asynchronous, active-low
//   fifo     async_fifo_if.slave: W_INC/WR_DATA/FULL on W_CLK,
//            R_INC/EMPTY/RD_DATA on R_CLK
//
// Each side keeps an ADDR_W+1 bit binary pointer (the extra bit counts laps so
// full and empty are distinguishable) plus a registered Gray copy. Only the
// Gray copies cross domains, through two-flop synchronizers. Both flags are
// computed from local registered state, so they update on the same edge as the
// local push/pop and can only be pessimistic about the far side.
// -----------------------------------------------------------------------------
module async_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEP   = 8
) (
  input  logic        W_CLK,
  input  logic        W_RST,
  input  logic        R_CLK,
  input  logic        R_RST,
  async_fifo_if.slave fifo
);

  localparam int ADDR_W = $clog2(DATA_DEP);

  typedef logic [ADDR_W:0]       ptr_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

  function automatic ptr_t bin2gray(input ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  word_t mem [DATA_DEP];

  // ---------------------------------------------------------------------------
  // Write domain
  // ---------------------------------------------------------------------------
  ptr_t wptr_q, wptr_d;
  ptr_t wgray_q, wgray_d;
  ptr_t wq1_rgray_q, wq2_rgray_q;   // read Gray pointer, synchronized to W_CLK
  ptr_t rgray_q;                    // declared here, driven in the read domain
  logic full;
  logic push;

  // Full: write pointer is exactly one lap ahead of the read pointer. In Gray
  // code a one-lap offset shows up as the two MSBs inverted, the rest equal.
  assign full = (wgray_q == {~wq2_rgray_q[ADDR_W -: 2], wq2_rgray_q[ADDR_W-2:0]});
  assign push = fifo.W_INC && !full;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    wptr_d = wptr_q;
    if (push) begin
      wptr_d = wptr_q + ptr_t'(1);
    end
    wgray_d = bin2gray(wptr_d);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would make the synchronizer stages
  // collapse into one and order-dependent simulation results.
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      wptr_q      <= '0;
      wgray_q     <= '0;
      wq1_rgray_q <= '0;
      wq2_rgray_q <= '0;
    end else begin
      wptr_q      <= wptr_d;
      wgray_q     <= wgray_d;
      // Gray code changes one bit per step, so a sample taken mid-transition
      // resolves to either the old or the new pointer, never a stray value.
      wq1_rgray_q <= rgray_q;
      wq2_rgray_q <= wq1_rgray_q;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are valid, and a reset term would stop it mapping onto RAM.
  always_ff @(posedge W_CLK) begin
    if (push) begin
      mem[wptr_q[ADDR_W-1:0]] <= fifo.WR_DATA;
    end
  end

  assign fifo.FULL = full;

  // ---------------------------------------------------------------------------
  // Read domain
  // ---------------------------------------------------------------------------
  ptr_t  rptr_q, rptr_d;
  ptr_t  rgray_d;
  ptr_t  rq1_wgray_q, rq2_wgray_q;  // write Gray pointer, synchronized to R_CLK
  word_t rd_data_q, rd_data_d;
  logic  empty;
  logic  pop;

  assign empty = (rgray_q == rq2_wgray_q);
  assign pop   = fifo.R_INC && !empty;

  always_comb begin
    rptr_d    = rptr_q;
    rd_data_d = rd_data_q;          // output holds unless a pop is taken
    if (pop) begin
      rptr_d    = rptr_q + ptr_t'(1);
      rd_data_d = mem[rptr_q[ADDR_W-1:0]];
    end
    rgray_d = bin2gray(rptr_d);
  end

  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      rptr_q      <= '0;
      rgray_q     <= '0;
      rq1_wgray_q <= '0;
      rq2_wgray_q <= '0;
      rd_data_q   <= '0;
    end else begin
      rptr_q      <= rptr_d;
      rgray_q     <= rgray_d;
      rq1_wgray_q <= wgray_q;
      rq2_wgray_q <= rq1_wgray_q;
      rd_data_q   <= rd_data_d;
    end
  end

  assign fifo.EMPTY   = empty;
  assign fifo.RD_DATA = rd_data_q;

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  // A refused push must leave the write pointer alone.
  a_no_push_when_full : assert property (
    @(posedge W_CLK) disable iff (!W_RST)
      (fifo.W_INC && full) |=> $stable(wptr_q)
  );

  // A refused pop must leave the read pointer and the output register alone.
  a_no_pop_when_empty : assert property (
    @(posedge R_CLK) disable iff (!R_RST)
      (fifo.R_INC && empty) |=> ($stable(rptr_q) && $stable(rd_data_q))
  );

endmodule : async_fifo

// File: tb/tb_async_fifo.sv
// -----------------------------------------------------------------------------
// tb_async_fifo -- self-checking bench for async_fifo (8 x 8).
//
// A scoreboard queue receives every accepted push and is popped on every
// accepted pop. An occupancy counter (pushes minus pops as the bench sees them)
// checks that FULL never claims space and EMPTY never claims data that is not
// there. A vector table covers the fill-to-full / drain-to-empty corner; hand
// sequences cover back-to-back streaming, pointer wrap with concurrent traffic
// and mid-stream asynchronous reset.
// -----------------------------------------------------------------------------
module tb_async_fifo;

  localparam int DW  = 8;
  localparam int DEP = 8;

  logic w_clk = 1'b0;
  logic r_clk = 1'b0;
  logic w_rst;
  logic r_rst;

  async_fifo_if #(.DATA_WIDTH(DW)) fifo_if ();

  async_fifo #(
    .DATA_WIDTH (DW),
    .DATA_DEP   (DEP)
  ) dut (
    .W_CLK (w_clk),
    .W_RST (w_rst),
    .R_CLK (r_clk),
    .R_RST (r_rst),
    .fifo  (fifo_if)
  );

  // W_CLK 10 ns, R_CLK 25 ns, read clock phase-offset from the write clock.
  always #5ns w_clk = ~w_clk;
  initial begin
    #3ns;
    forever #12.5ns r_clk = ~r_clk;
  end

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  int occ     = 0;
  logic [DW-1:0] sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One write-clock push attempt; acc reports whether FULL allowed it.
  task automatic do_push(input logic [DW-1:0] d, output bit acc);
    @(negedge w_clk);
    fifo_if.W_INC   = 1'b1;
    fifo_if.WR_DATA = d;
    acc = (fifo_if.FULL == 1'b0);
    @(posedge w_clk);
    #1ns;
    fifo_if.W_INC = 1'b0;
    if (acc) begin
      sb.push_back(d);
      occ++;
    end
    check("full_honest", 32'((fifo_if.FULL == 1'b0) && (occ >= DEP)), 32'd0);
  endtask

  task automatic push_retry(input logic [DW-1:0] d);
    bit acc;
    int tries;
    tries = 0;
    do begin
      do_push(d, acc);
      tries++;
    end while (!acc && tries < 200);
    if (!acc) check("push_timeout", 32'd0, 32'd1);
  endtask

  // One read-clock pop attempt. only_if_ready=1 raises R_INC only when EMPTY=0;
  // otherwise R_INC is raised unconditionally (exercises refused reads).
  task automatic do_pop(input bit only_if_ready, output bit acc);
    logic [DW-1:0] exp_d;
    @(negedge r_clk);
    acc = (fifo_if.EMPTY == 1'b0);
    fifo_if.R_INC = only_if_ready ? acc : 1'b1;
    @(posedge r_clk);
    #1ns;
    fifo_if.R_INC = 1'b0;
    if (acc) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_d = sb.pop_front();
        occ--;
        check("rd_data", 32'(fifo_if.RD_DATA), 32'(exp_d));
      end
    end
    check("empty_honest", 32'((fifo_if.EMPTY == 1'b0) && (occ <= 0)), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Fill/drain vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    bit            w_inc;
    bit            r_inc;
    logic [DW-1:0] data;
    bit            exp_acc;
    bit            exp_full;
    logic [DW-1:0] exp_rd;
    bit            exp_empty;
    int            settle;      // R_CLK cycles to wait before applying
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(input bit w, input bit r, input logic [DW-1:0] d,
                              input bit ea, input bit ef, input logic [DW-1:0] er,
                              input bit ee, input int s);
    vec_t v;
    v.w_inc = w; v.r_inc = r; v.data = d; v.exp_acc = ea; v.exp_full = ef;
    v.exp_rd = er; v.exp_empty = ee; v.settle = s;
    return v;
  endfunction

  logic [DW-1:0] seq1 [8] = '{8'hB9, 8'h64, 8'h3E, 8'h2A, 8'h1D, 8'h48, 8'hBF, 8'h5C};

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int got;

    // Push 00..07 (FULL only after the 8th), 9th push of AA refused.
    for (int i = 0; i < 8; i++) tbl[i] = mk(1, 0, 8'(i), 1, (i == 7), 8'h00, 0, 0);
    tbl[8] = mk(1, 0, 8'hAA, 0, 1, 8'h00, 0, 0);
    // Pop 00..07, EMPTY after the 8th, then a refused pop holds 07.
    for (int i = 0; i < 8; i++) tbl[9+i] = mk(0, 1, 8'h00, 0, 0, 8'(i), (i == 7), (i == 0) ? 4 : 0);
    tbl[17] = mk(0, 1, 8'h00, 0, 0, 8'h07, 1, 0);

    fifo_if.W_INC   = 1'b0;
    fifo_if.WR_DATA = '0;
    fifo_if.R_INC   = 1'b0;

    // ---- reset both domains ----
    w_rst = 1'b0;
    r_rst = 1'b0;
    #20ns;
    check("rst_empty", 32'(fifo_if.EMPTY), 32'd1);
    check("rst_full", 32'(fifo_if.FULL), 32'd0);
    check("rst_rd_data", 32'(fifo_if.RD_DATA), 32'h00);
    @(negedge w_clk) w_rst = 1'b1;
    @(negedge r_clk) r_rst = 1'b1;
    repeat (3) @(posedge r_clk);
    #1ns;
    check("post_rst_empty", 32'(fifo_if.EMPTY), 32'd1);
    check("post_rst_full", 32'(fifo_if.FULL), 32'd0);
    check("post_rst_rd_data", 32'(fifo_if.RD_DATA), 32'h00);

    // ---- streaming: push eight words, pop whenever EMPTY=0 ----
    fork
      begin
        for (int i = 0; i < 8; i++) push_retry(seq1[i]);
      end
      begin
        got = 0;
        for (int c = 0; c < 200 && got < 8; c++) begin
          do_pop(1'b1, acc);
          if (acc) got++;
        end
        check("stream_pop_count", 32'(got), 32'd8);
      end
    join
    check("stream_empty_end", 32'(fifo_if.EMPTY), 32'd1);
    check("stream_sb_drained", 32'(sb.size()), 32'd0);
    check("stream_last_word", 32'(fifo_if.RD_DATA), 32'h5C);

    // Let the read pointer reach the write domain before filling.
    repeat (6) @(posedge w_clk);

    // ---- fill to full, then drain to empty (table) ----
    for (int i = 0; i < 18; i++) begin
      repeat (tbl[i].settle) @(posedge r_clk);
      if (tbl[i].w_inc) begin
        do_push(tbl[i].data, acc);
        check($sformatf("vec%0d_accept", i), 32'(acc), 32'(tbl[i].exp_acc));
        check($sformatf("vec%0d_full", i), 32'(fifo_if.FULL), 32'(tbl[i].exp_full));
      end
      if (tbl[i].r_inc) begin
        do_pop(1'b0, acc);
        check($sformatf("vec%0d_rd_data", i), 32'(fifo_if.RD_DATA), 32'(tbl[i].exp_rd));
        check($sformatf("vec%0d_empty", i), 32'(fifo_if.EMPTY), 32'(tbl[i].exp_empty));
      end
    end

    // ---- 20 words through pointer wrap with concurrent push/pop ----
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge w_clk);
          push_retry(8'($urandom_range(1, 255)));
        end
      end
      begin
        got = 0;
        for (int c = 0; c < 2000 && got < 20; c++) begin
          if ($urandom_range(0, 3) == 0) @(posedge r_clk);
          do_pop(1'b1, acc);
          if (acc) got++;
        end
        check("wrap_pop_count", 32'(got), 32'd20);
      end
    join
    repeat (4) @(posedge w_clk);
    #1ns;
    check("wrap_sb_drained", 32'(sb.size()), 32'd0);
    check("wrap_empty", 32'(fifo_if.EMPTY), 32'd1);
    check("wrap_full", 32'(fifo_if.FULL), 32'd0);

    // ---- mid-stream reset of both domains ----
    for (int i = 0; i < 8; i++) push_retry(8'(8'h30 + i));
    repeat (4) @(posedge r_clk);
    #1ns;
    check("pre_rst_full", 32'(fifo_if.FULL), 32'd1);
    check("pre_rst_empty", 32'(fifo_if.EMPTY), 32'd0);
    check("pre_rst_rd_nonzero", 32'(fifo_if.RD_DATA != 8'h00), 32'd1);
    @(negedge w_clk);
    #2ns;
    w_rst = 1'b0;
    r_rst = 1'b0;
    #1ns;
    check("async_rst_empty", 32'(fifo_if.EMPTY), 32'd1);
    check("async_rst_full", 32'(fifo_if.FULL), 32'd0);
    check("async_rst_rd_data", 32'(fifo_if.RD_DATA), 32'h00);
    sb.delete();
    occ = 0;
    @(negedge w_clk) w_rst = 1'b1;
    @(negedge r_clk) r_rst = 1'b1;

    // FIFO is usable again after reset.
    push_retry(8'h5A);
    got = 0;
    for (int c = 0; c < 20 && got < 1; c++) begin
      do_pop(1'b1, acc);
      if (acc) got++;
    end
    check("after_rst_pop_count", 32'(got), 32'd1);
    check("after_rst_rd_data", 32'(fifo_if.RD_DATA), 32'h5A);
    check("after_rst_empty", 32'(fifo_if.EMPTY), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_async_fifo
